mem_access: RTL and testbench
=============================

# mem_access

MEM-stage data-memory access unit for the 5-stage MIPS pipeline. It consumes the EX/MEM pipeline register outputs and performs word loads and stores over a request/grant/data_ok data bus. While a bus transaction is outstanding it raises a stall request. It delivers the write-back result (load data or ALU result) to the MEM/WB register.

## Interface
Parameters:
- none; all widths are fixed at 32-bit data/address and a 5-bit register number.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `stall`  in  6  pipeline stall vector; bit 4 = MEM/WB hold (`Stop`=1)
- `i_write_mem`  in  1  store request from EX/MEM
- `i_write_regfile`  in  1  instruction writes the register file
- `i_mem_to_regfile`  in  1  load; write-back value comes from memory
- `i_da`  in  32  ALU result; the memory address for loads/stores
- `i_db`  in  32  store data
- `i_rn`  in  5  destination register
- `o_write_regfile`  out  1  to MEM/WB
- `o_rn`  out  5  to MEM/WB
- `o_wdata`  out  32  write-back value to MEM/WB
- `o_stallreq`  out  1  request freeze of stages 0..3
- `o_adel`  out  1  misaligned load address
- `o_ades`  out  1  misaligned store address
- `bus_req`  out  1  transaction request
- `bus_wr`  out  1  1=store, 0=load
- `bus_addr`  out  32  word address; bits [1:0]=00
- `bus_wdata`  out  32  store data
- `bus_gnt`  in  1  address phase accepted
- `bus_data_ok`  in  1  data phase complete; `bus_rdata` valid
- `bus_rdata`  in  32  load data

## Operation
- A memory op is `mop = i_write_mem | i_mem_to_regfile`. The address is misaligned when `i_da[1:0] != 0`.
- FSM states: `IDLE`, `REQ`, `WAIT`, `DONE`.
  - `IDLE`:
    - aligned `mop` → `REQ`; `o_stallreq`=1 (combinational) in the same cycle.
    - misaligned `mop` → stay in `IDLE`; no bus access; `o_adel`/`o_ades`=1; `o_write_regfile`=0.
    - non-memory op → pass-through with zero latency: `o_wdata=i_da`, `o_write_regfile=i_write_regfile`.
  - `REQ`:
    - `bus_req`=1. `bus_wr`, `bus_addr` and `bus_wdata` are registered copies of `i_write_mem`, `i_da` and `i_db`, captured on leaving `IDLE`.
    - `bus_gnt`=0 → stay; `bus_gnt`=1 → `WAIT`.
    - `bus_gnt` and `bus_data_ok` both 1 in the same cycle → `DONE` directly.
  - `WAIT`: `bus_req`=0; `bus_data_ok`=1 → `DONE`, and a load latches `bus_rdata` into `rdata_q`.
  - `DONE`:
    - `o_stallreq`=0.
    - outputs valid: `o_wdata` = `rdata_q` for a load, `i_da` for a store; `o_write_regfile=i_write_regfile`.
    - `stall[4]`=`NoStop` → `IDLE`; `Stop` → hold `DONE` with no reissue.
- `o_stallreq`=1 in `IDLE` (when an aligned `mop` is present), in `REQ` and in `WAIT`.
- While `o_stallreq` is high, `o_write_regfile`=0 so no bubble is committed.
- EX/MEM inputs are stable while `o_stallreq` is high; the block relies on this.

## Timing
- Reset values:
  - state `IDLE`
  - `bus_req`, `bus_wr`=0; `bus_addr`, `bus_wdata`=`ZeroWord`
  - `rdata_q`=`ZeroWord`
  - `o_stallreq`, `o_adel`, `o_ades`=0
  - `o_write_regfile`=0, `o_rn`=0, `o_wdata`=`ZeroWord`
- Reset mid-transaction → `IDLE` on the next edge; `bus_req` drops. The bus responder shares the same reset, and any in-flight `data_ok` is discarded.
- Minimum load/store latency with `gnt` in the first `REQ` cycle and `data_ok` one cycle later: cycles C0 `IDLE`, C1 `REQ`, C2 `WAIT`, C3 `DONE`. That is 3 stall cycles.
- With `gnt` and `data_ok` in the same cycle: 2 stall cycles.
- `bus_req` stays asserted until `gnt`. Address and data must not change while `bus_req`=1.
- Exactly one bus request is issued per memory instruction. `DONE` held by `stall[4]` never reissues.
- `data_ok` received in `IDLE` or `DONE` is ignored.

## Structure
- The shared `mips_defines` package holds `Stop`, `NoStop`, `ZeroWord`, `ZeroBit` and the FSM state encoding `MEM_IDLE`, `MEM_REQ`, `MEM_WAIT`, `MEM_DONE`.
- Single module, no sub-modules. The FSM, bus registers and `rdata_q` live together.

## Test plan
- ALU op `i_da`=0x1234, `i_write_regfile`=1, `i_rn`=5 → same cycle: `o_wdata`=0x1234, `o_rn`=5, `o_stallreq`=0, no `bus_req`.
- Load `i_da`=0x100; `gnt` at C1; `data_ok` at C2 with `rdata`=0xDEADBEEF → `o_stallreq` high C0–C2; C3: `o_wdata`=0xDEADBEEF, `o_write_regfile`=1.
- Store `i_da`=0x200, `i_db`=0xA5A5A5A5; `gnt` delayed 3 cycles → `bus_req` held 3 cycles with `bus_addr`=0x200, `bus_wr`=1, `bus_wdata` stable; exactly one grant accepted.
- Load at 0x102 → `o_adel`=1, `o_write_regfile`=0, no `bus_req`. Store at 0x203 → `o_ades`=1.
- Load reaches `DONE` with `stall[4]`=1 for 2 cycles → state held, `o_wdata` stable, no second `bus_req`; returns to `IDLE` when released.
- Reset asserted in `WAIT`, then a late `data_ok` → state `IDLE`, all outputs at reset values, late `data_ok` ignored.

Source files
------------

// File: rtl/mips_defines.sv
// Shared MIPS pipeline definitions.
// Holds the pipeline stall encodings, zero constants, the MEM-stage access
// FSM state encoding and a small address-alignment helper used by the
// MEM-stage data-memory access unit.
package mips_defines;

  // Stall vector bit values: Stop freezes a stage, NoStop lets it advance.
  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  localparam logic        ZeroBit  = 1'b0;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  // MEM-stage data-memory access FSM encoding.
  localparam logic [1:0] MEM_IDLE = 2'd0;
  localparam logic [1:0] MEM_REQ  = 2'd1;
  localparam logic [1:0] MEM_WAIT = 2'd2;
  localparam logic [1:0] MEM_DONE = 2'd3;

  // Word accesses must sit on a 4-byte boundary.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/mem_access.sv
// MEM-stage data-memory access unit for the 5-stage MIPS pipeline.
// Takes the EX/MEM register outputs, performs word loads/stores over a
// request/grant/data_ok bus, raises a stall request while a transaction is
// outstanding and presents the write-back value to the MEM/WB register.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   stall[5:0]          pipeline stall vector, bit 4 holds MEM/WB
//   i_write_mem         store request
//   i_write_regfile     instruction writes the register file
//   i_mem_to_regfile    load; write-back value comes from memory
//   i_da, i_db          ALU result / memory address, store data
//   i_rn                destination register
//   o_write_regfile,
//   o_rn, o_wdata       write-back info to MEM/WB
//   o_stallreq          freeze request for stages 0..3
//   o_adel, o_ades      misaligned load / store address
//   bus_req, bus_wr,
//   bus_addr, bus_wdata request side of the data bus
//   bus_gnt, bus_data_ok,
//   bus_rdata           response side of the data bus
module mem_access
  import mips_defines::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  stall,
  input  logic        i_write_mem,
  input  logic        i_write_regfile,
  input  logic        i_mem_to_regfile,
  input  logic [31:0] i_da,
  input  logic [31:0] i_db,
  input  logic [4:0]  i_rn,
  output logic        o_write_regfile,
  output logic [4:0]  o_rn,
  output logic [31:0] o_wdata,
  output logic        o_stallreq,
  output logic        o_adel,
  output logic        o_ades,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  logic [1:0]  state_q, state_d;
  logic        bus_wr_q, bus_wr_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic mop;
  logic misaligned;
  logic start;
  logic in_idle, in_req, in_wait, in_done;

  // Only stall[4] (MEM/WB hold) matters to this stage.
  logic unused_stall;
  assign unused_stall = ^{stall[5], stall[3:0]};

  assign mop        = i_write_mem | i_mem_to_regfile;
  assign misaligned = is_misaligned(i_da);
  assign start      = mop & ~misaligned;

  assign in_idle = (state_q == MEM_IDLE);
  assign in_req  = (state_q == MEM_REQ);
  assign in_wait = (state_q == MEM_WAIT);
  assign in_done = (state_q == MEM_DONE);

  always_comb begin
    state_d     = state_q;
    bus_wr_d    = bus_wr_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
    case (state_q)
      MEM_IDLE: begin
        // Bus fields are frozen here so they cannot move while bus_req is up.
        if (start) begin
          state_d     = MEM_REQ;
          bus_wr_d    = i_write_mem;
          bus_addr_d  = {i_da[31:2], 2'b00};
          bus_wdata_d = i_db;
        end
      end
      MEM_REQ: begin
        // data_ok without gnt is not a valid response and is ignored.
        if (bus_gnt) begin
          if (bus_data_ok) begin
            state_d = MEM_DONE;
            if (!bus_wr_q) rdata_d = bus_rdata;
          end else begin
            state_d = MEM_WAIT;
          end
        end
      end
      MEM_WAIT: begin
        if (bus_data_ok) begin
          state_d = MEM_DONE;
          if (!bus_wr_q) rdata_d = bus_rdata;
        end
      end
      MEM_DONE: begin
        // Held by MEM/WB: stay here without touching the bus again.
        if (stall[4] == NoStop) state_d = MEM_IDLE;
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= MEM_IDLE;
      bus_wr_q    <= ZeroBit;
      bus_addr_q  <= ZeroWord;
      bus_wdata_q <= ZeroWord;
      rdata_q     <= ZeroWord;
    end else begin
      state_q     <= state_d;
      bus_wr_q    <= bus_wr_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus_req   = in_req;
  assign bus_wr    = bus_wr_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;

  // Pipeline-facing outputs are combinational so ALU results pass with zero
  // latency; they are forced to their idle values while reset is held.
  always_comb begin
    o_stallreq      = 1'b0;
    o_write_regfile = 1'b0;
    o_rn            = 5'd0;
    o_wdata         = ZeroWord;
    o_adel          = 1'b0;
    o_ades          = 1'b0;
    if (!reset) begin
      o_stallreq = (in_idle & start) | in_req | in_wait;
      o_rn       = i_rn;
      o_wdata    = (in_done && !bus_wr_q) ? rdata_q : i_da;
      o_adel     = in_idle & i_mem_to_regfile & misaligned;
      o_ades     = in_idle & i_write_mem & misaligned;
      // Any memory op in IDLE is either stalling or faulting: no commit.
      if (in_idle)      o_write_regfile = i_write_regfile & ~mop;
      else if (in_done) o_write_regfile = i_write_regfile;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  stall;
  logic        i_write_mem, i_write_regfile, i_mem_to_regfile;
  logic [31:0] i_da, i_db;
  logic [4:0]  i_rn;
  logic        o_write_regfile;
  logic [4:0]  o_rn;
  logic [31:0] o_wdata;
  logic        o_stallreq, o_adel, o_ades;
  logic        bus_req, bus_wr;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_gnt, bus_data_ok;
  logic [31:0] bus_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access dut (
    .clk(clk), .reset(reset), .stall(stall),
    .i_write_mem(i_write_mem), .i_write_regfile(i_write_regfile),
    .i_mem_to_regfile(i_mem_to_regfile), .i_da(i_da), .i_db(i_db), .i_rn(i_rn),
    .o_write_regfile(o_write_regfile), .o_rn(o_rn), .o_wdata(o_wdata),
    .o_stallreq(o_stallreq), .o_adel(o_adel), .o_ades(o_ades),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive_instr(input logic wm, input logic m2r, input logic wrf,
                             input logic [31:0] da, input logic [31:0] db, input logic [4:0] rn);
    i_write_mem = wm; i_mem_to_regfile = m2r; i_write_regfile = wrf;
    i_da = da; i_db = db; i_rn = rn;
  endtask

  // Runs one instruction through MEM. The responder grants gd cycles after the
  // request first appears and returns data lat cycles after the grant (0 = same
  // cycle); DONE is then held by stall[4] for hold cycles, with stray data_ok
  // pulses carrying junk that must be ignored.
  task automatic run_op(input logic wm, input logic m2r, input logic wrf,
                        input logic [31:0] da, input logic [31:0] db, input logic [4:0] rn,
                        input int gd, input int lat, input int hold, input logic [31:0] rd);
    logic mop, mis;
    int exp_done, stall_cnt, req_cnt, grants;
    logic [31:0] exp_wdata;
    mop = wm | m2r;
    mis = (da % 4) != 0;
    @(posedge clk); #1;
    drive_instr(wm, m2r, wrf, da, db, rn);
    bus_gnt = 0; bus_data_ok = 0; stall = 6'd0;
    if (!mop || mis) begin
      @(negedge clk);
      if (!mop) chk("pass_wdata", o_wdata, da);
      chk("pass_wrf", o_write_regfile, mop ? 1'b0 : wrf);
      chk("pass_rn", o_rn, rn);
      chk("pass_stallreq", o_stallreq, 0);
      chk("pass_busreq", bus_req, 0);
      chk("adel", o_adel, m2r & mis);
      chk("ades", o_ades, wm & mis);
      $display("op alu/misaligned da=%h wm=%0d m2r=%0d adel=%0d ades=%0d", da, wm, m2r, o_adel, o_ades);
      return;
    end
    exp_done  = 2 + gd + lat;
    exp_wdata = m2r ? rd : da;
    stall_cnt = 0; req_cnt = 0; grants = 0;
    for (int c = 0; c <= exp_done + hold; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      bus_gnt     = (c == 1 + gd);
      bus_data_ok = (c == 1 + gd + lat) || (c >= exp_done);
      bus_rdata   = (c == 1 + gd + lat) ? rd : ~rd;
      stall       = {1'b0, (c >= exp_done && c < exp_done + hold), 4'd0};
      @(negedge clk);
      if (o_stallreq) stall_cnt++;
      if (bus_req) begin
        req_cnt++;
        if (bus_gnt) grants++;
        chk("bus_addr", bus_addr, da);
        chk("bus_wr", bus_wr, wm);
        chk("bus_wdata", bus_wdata, db);
      end
      chk("bus_req_cycle", bus_req, (c >= 1 && c <= 1 + gd));
      if (c < exp_done) begin
        chk("stall_phase_stallreq", o_stallreq, 1);
        chk("stall_phase_wrf", o_write_regfile, 0);
      end else begin
        chk("done_stallreq", o_stallreq, 0);
        chk("done_wdata", o_wdata, exp_wdata);
        chk("done_wrf", o_write_regfile, wrf);
        chk("done_rn", o_rn, rn);
      end
    end
    chk("stall_cycles", stall_cnt, exp_done);
    chk("req_cycles", req_cnt, gd + 1);
    chk("grants", grants, 1);
    $display("op %s da=%h gd=%0d lat=%0d hold=%0d stall_cycles=%0d wdata=%h",
             m2r ? "load" : "store", da, gd, lat, hold, stall_cnt, o_wdata);
    bus_gnt = 0; bus_data_ok = 0; stall = 6'd0;
  endtask

  typedef struct {
    logic        wm, m2r, wrf;
    logic [31:0] da;
    logic [4:0]  rn;
    logic [31:0] exp_wdata;
    logic        exp_wrf, exp_adel, exp_ades;
  } tv_t;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tv_t tv[7];
    logic [31:0] r;
    int kind;
    tv[0] = '{0, 0, 1, 32'h0000_1234, 5'd5,  32'h0000_1234, 1, 0, 0};
    tv[1] = '{0, 0, 0, 32'hFFFF_FFFF, 5'd31, 32'hFFFF_FFFF, 0, 0, 0};
    tv[2] = '{0, 0, 1, 32'h0000_0003, 5'd1,  32'h0000_0003, 1, 0, 0};
    tv[3] = '{0, 1, 1, 32'h0000_0102, 5'd7,  32'h0,         0, 1, 0};
    tv[4] = '{1, 0, 0, 32'h0000_0203, 5'd0,  32'h0,         0, 0, 1};
    tv[5] = '{0, 1, 1, 32'h0000_0101, 5'd3,  32'h0,         0, 1, 0};
    tv[6] = '{1, 0, 0, 32'h0000_0202, 5'd4,  32'h0,         0, 0, 1};

    reset = 1; stall = 6'd0; bus_gnt = 0; bus_data_ok = 0; bus_rdata = 32'h1111_2222;
    drive_instr(0, 0, 1, 32'h0000_1234, 32'h5555_5555, 5'd5);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wdata", o_wdata, 0);
    chk("rst_rn", o_rn, 0);
    chk("rst_wrf", o_write_regfile, 0);
    chk("rst_stallreq", o_stallreq, 0);
    chk("rst_adel_ades", {o_adel, o_ades}, 0);
    chk("rst_bus_req_wr", {bus_req, bus_wr}, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_wdata", bus_wdata, 0);
    $display("reset state checked");
    @(posedge clk); #1; reset = 0;

    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      drive_instr(tv[i].wm, tv[i].m2r, tv[i].wrf, tv[i].da, 32'hCAFE_0000, tv[i].rn);
      @(negedge clk);
      if (!(tv[i].wm | tv[i].m2r)) chk("tv_wdata", o_wdata, tv[i].exp_wdata);
      chk("tv_wrf", o_write_regfile, tv[i].exp_wrf);
      chk("tv_rn", o_rn, tv[i].rn);
      chk("tv_adel", o_adel, tv[i].exp_adel);
      chk("tv_ades", o_ades, tv[i].exp_ades);
      chk("tv_stallreq", o_stallreq, 0);
      chk("tv_busreq", bus_req, 0);
      $display("vector %0d da=%h wdata=%h wrf=%0d adel=%0d ades=%0d", i, tv[i].da, o_wdata,
               o_write_regfile, o_adel, o_ades);
    end

    // Minimum-latency load, delayed-grant store, same-cycle gnt+data_ok, held DONE.
    run_op(0, 1, 1, 32'h0000_0100, 32'h0, 5'd8, 0, 1, 0, 32'hDEAD_BEEF);
    run_op(1, 0, 0, 32'h0000_0200, 32'hA5A5_A5A5, 5'd0, 3, 1, 0, 32'h0);
    run_op(0, 1, 1, 32'h0000_0400, 32'h0, 5'd9, 0, 0, 0, 32'h1357_9BDF);
    run_op(0, 1, 1, 32'h0000_0500, 32'h0, 5'd10, 1, 2, 2, 32'h0BAD_F00D);
    run_op(0, 0, 1, 32'h0000_1234, 32'h0, 5'd5, 0, 0, 0, 32'h0);

    // Reset while in WAIT, then a late data_ok.
    @(posedge clk); #1;
    drive_instr(0, 1, 1, 32'h0000_0300, 32'h0, 5'd9);
    bus_gnt = 0; bus_data_ok = 0; stall = 6'd0;
    @(posedge clk); #1; bus_gnt = 1;
    @(posedge clk); #1; bus_gnt = 0; reset = 1;
    @(negedge clk);
    chk("rstwait_stallreq", o_stallreq, 0);
    chk("rstwait_wdata", o_wdata, 0);
    chk("rstwait_wrf", o_write_regfile, 0);
    @(posedge clk); #1; reset = 0;
    drive_instr(0, 0, 0, 32'h0, 32'h0, 5'd0);
    bus_data_ok = 1; bus_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    chk("late_ok_stallreq", o_stallreq, 0);
    chk("late_ok_busreq", bus_req, 0);
    chk("late_ok_bus_addr", bus_addr, 0);
    chk("late_ok_bus_wdata", bus_wdata, 0);
    chk("late_ok_bus_wr", bus_wr, 0);
    chk("late_ok_wdata", o_wdata, 0);
    chk("late_ok_wrf_rn", {o_write_regfile, o_rn}, 0);
    @(posedge clk); #1; bus_data_ok = 0;
    @(negedge clk);
    chk("late_ok_idle", o_stallreq, 0);
    $display("reset in WAIT with late data_ok checked");

    for (int n = 0; n < 40; n++) begin
      r = $urandom;
      kind = $urandom_range(0, 4);
      case (kind)
        0: run_op(0, 0, 1'($urandom_range(0, 1)), r, $urandom, 5'($urandom_range(0, 31)), 0, 0, 0, 0);
        1: run_op(0, 1, 1, {r[31:2], 2'b00}, $urandom, 5'($urandom_range(0, 31)),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), $urandom);
        2: run_op(1, 0, 1'($urandom_range(0, 1)), {r[31:2], 2'b00}, $urandom, 5'($urandom_range(0, 31)),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), $urandom);
        3: run_op(0, 1, 1, {r[31:2], 2'($urandom_range(1, 3))}, $urandom, 5'($urandom_range(0, 31)),
                  0, 0, 0, 0);
        default: run_op(1, 0, 0, {r[31:2], 2'($urandom_range(1, 3))}, $urandom,
                        5'($urandom_range(0, 31)), 0, 0, 0, 0);
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
